// File: rtl/replicate_serializer.sv
// Bit-serial transmitter: emits {N{pattern}} MSB-first, one bit per output handshake.
// Define REPLICATE_SERIALIZER_PARITY_EN to append an even-parity bit to every non-empty frame.
module replicate_serializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pattern,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             par_q, par_d;
  logic             last_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once out_valid is raised it stays high with out_bit/out_last stable until accepted.
  assign last_data = (rep_q == CNT_W'(1)) && (idx_q == '0);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    par_d     = par_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = in_pattern;
          hold_d  = in_pattern;
          rep_d   = in_count;
          idx_d   = IDX_MAX;
          par_d   = 1'b0;
          // A zero count consumes the request without emitting anything.
          if (in_count != '0) state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_valid = 1'b1;
        out_bit   = shift_q[WIDTH-1];
`ifndef REPLICATE_SERIALIZER_PARITY_EN
        out_last  = last_data;
`endif
        if (out_ready) begin
          par_d = par_q ^ shift_q[WIDTH-1];
          if (idx_q == '0) begin
            shift_d = hold_q;
            idx_d   = IDX_MAX;
            rep_d   = (rep_q == '0) ? '0 : rep_q - CNT_W'(1);
          end else begin
            shift_d = shift_q << 1;
            idx_d   = idx_q - IDX_W'(1);
          end
          if (last_data) begin
`ifdef REPLICATE_SERIALIZER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef REPLICATE_SERIALIZER_PARITY_EN
      S_PARITY: begin
        out_valid = 1'b1;
        out_bit   = par_q;
        out_last  = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_replicate_serializer.sv
// Self-checking bench for replicate_serializer: table of frames plus reset and back-to-back sequences.
// Expected serial bits are pushed to a scoreboard queue and popped as the DUT emits them.
module tb_replicate_serializer;

`ifdef REPLICATE_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_pattern;
  logic [3:0] in_count;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [1:0] exp_q[$];

  replicate_serializer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pattern(in_pattern), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and stall-freeze monitor, sampled mid-cycle.
  logic       stalled_prev = 1'b0;
  logic [1:0] held = 2'b00;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev)
        check("stall_hold", {out_valid, out_last, out_bit}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'(exp_q.size()), 32'd1);
        end else begin
          check("bit", {out_last, out_bit}, exp_q.pop_front());
        end
        acc_cnt++;
      end
      stalled_prev = out_valid && !out_ready;
      held = {out_last, out_bit};
    end
  end

  task automatic push_frame(input logic [3:0] pat, input logic [3:0] n);
    logic par;
    logic [3:0] p;
    par = 1'b0;
    p = pat;
    for (int r = 0; r < int'(n); r++) begin
      for (int i = 3; i >= 0; i--) begin
        par = par ^ p[i];
        exp_q.push_back({(P == 0) && (r == int'(n) - 1) && (i == 0), p[i]});
      end
    end
    if (P == 1 && n != 4'd0) exp_q.push_back({1'b1, par});
  endtask

  task automatic send_frame(input logic [3:0] pat, input logic [3:0] n, input int mode,
                            input int exp_len);
    int waitc;
    int cyc;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_before_frame", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_pattern = pat;
    in_count = n;
    acc_cnt = 0;
    push_frame(pat, n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (n == 4'd0) begin
      for (int k = 0; k < 3; k++) begin
        check("n0_out_valid", 32'(out_valid), 32'd0);
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
      end
      check("n0_len", 32'(acc_cnt), 32'(exp_len));
      return;
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("busy_in_frame", 32'(busy), 32'd1);
    check("in_ready_in_frame", 32'(in_ready), 32'd0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_pattern = 4'($urandom_range(0, 15));
      in_count = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check("frame_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    out_ready = 1'b1;
    check("frame_len", 32'(acc_cnt), 32'(exp_len));
    check("idle_gap_in_ready", 32'(in_ready), 32'd1);
    check("idle_gap_out_valid", 32'(out_valid), 32'd0);
    check("idle_gap_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0] pattern;
    logic [3:0] count;
    int         mode;
    int         exp_len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int waitc;
    vecs[0] = '{4'b1001, 4'd4, 0, 16 + P};
    vecs[1] = '{4'b0001, 4'd1, 0, 4 + P};
    vecs[2] = '{4'b1011, 4'd2, 1, 8 + P};
    vecs[3] = '{4'b0101, 4'd0, 0, 0};
    vecs[4] = '{4'b1111, 4'd15, 2, 60 + P};
    vecs[5] = '{4'b0110, 4'd3, 2, 12 + P};
    vecs[6] = '{4'b1010, 4'd15, 1, 60 + P};
    vecs[7] = '{4'b1000, 4'd1, 2, 4 + P};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pattern = 4'h0;
    in_count = 4'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++)
      send_frame(vecs[v].pattern, vecs[v].count, vecs[v].mode, vecs[v].exp_len);

    // Back-to-back frames: the idle-gap checks inside send_frame cover the single IDLE cycle.
    send_frame(4'b1100, 4'd1, 0, 4 + P);
    send_frame(4'b0011, 4'd1, 0, 4 + P);

    // Reset in the middle of a frame aborts it immediately.
    in_valid = 1'b1;
    in_pattern = 4'b1001;
    in_count = 4'd4;
    acc_cnt = 0;
    push_frame(4'b1001, 4'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitc = 0;
    while (acc_cnt < 5 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("pre_reset_bits", 32'(acc_cnt), 32'd5);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    send_frame(4'b0110, 4'd1, 0, 4 + P);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
